// File: rtl/tk1_spi_slave_if.sv
// rtl/tk1_spi_slave_if.sv - byte-level rx/tx handshake bundle of the tk1 SPI responder
interface tk1_spi_slave_if;
  logic [7:0] rx_data;
  logic       rx_data_vld;
  logic       rx_ack;
  logic [7:0] tx_data;
  logic       tx_data_vld;
  logic       tx_ready;

  modport slave (
    output rx_data, rx_data_vld, tx_ready,
    input  rx_ack, tx_data, tx_data_vld
  );

  modport master (
    input  rx_data, rx_data_vld, tx_ready,
    output rx_ack, tx_data, tx_data_vld
  );
endinterface

// File: rtl/tk1_spi_slave.sv
// rtl/tk1_spi_slave.sv - SPI mode-0 responder, oversampled in clk; TK1_SPI_SLAVE_ERR_EN builds the sticky error flags
module tk1_spi_slave #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] IDLE_TX_BYTE = 8'hff
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_ss,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_en,
  tk1_spi_slave_if.slave    bus,
  output logic              frame_active,
  output logic              frame_end,
  input  logic              err_clear,
  output logic              rx_overrun,
  output logic              tx_underrun
);
  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d, sck_sync_q, sck_sync_d, mosi_sync_q, mosi_sync_d;
  logic                   ss_hist_q, ss_hist_d, sck_hist_q, sck_hist_d;
  logic [2:0]             bit_ctr_q, bit_ctr_d;
  logic [7:0]             rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [7:0]             rx_data_q, rx_data_d, txbuf_q, txbuf_d;
  logic                   rx_vld_q, rx_vld_d, txbuf_full_q, txbuf_full_d;
  logic                   first_rise_q, first_rise_d, frame_end_q, frame_end_d;
  logic                   load, ovr_evt, und_evt;
  logic                   ss_s, sck_s, mosi_s, ss_fall, ss_rise, sck_rise, sck_fall;
  logic [7:0]             rx_new;

  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall  = ss_hist_q & ~ss_s;
  assign ss_rise  = ~ss_hist_q & ss_s;
  assign sck_rise = ~sck_hist_q & sck_s;
  assign sck_fall = sck_hist_q & ~sck_s;
  assign rx_new   = {rx_shift_q[6:0], mosi_s};

  always_comb begin
    state_d      = state_q;
    ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0], spi_ss};
    sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    ss_hist_d    = ss_s;
    sck_hist_d   = sck_s;
    bit_ctr_d    = bit_ctr_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    rx_data_d    = rx_data_q;
    txbuf_d      = txbuf_q;
    rx_vld_d     = rx_vld_q;
    txbuf_full_d = txbuf_full_q;
    first_rise_d = first_rise_q;
    frame_end_d  = 1'b0;
    load         = 1'b0;
    ovr_evt      = 1'b0;
    und_evt      = 1'b0;

    if (bus.rx_ack) rx_vld_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d      = ST_ACTIVE;
          bit_ctr_d    = 3'd0;
          rx_shift_d   = 8'h00;
          first_rise_d = 1'b0;
          load         = 1'b1;
        end
      end
      default: begin
        if (ss_rise) begin
          state_d     = ST_IDLE;
          frame_end_d = 1'b1;
          bit_ctr_d   = 3'd0;
          rx_shift_d  = 8'h00;
          tx_shift_d  = 8'h00;
        end else if (sck_rise) begin
          rx_shift_d   = rx_new;
          bit_ctr_d    = bit_ctr_q + 3'd1;
          first_rise_d = 1'b1;
          if (bit_ctr_q == 3'd7) begin
            rx_data_d = rx_new;
            rx_vld_d  = 1'b1;
            ovr_evt   = rx_vld_q & ~bus.rx_ack;
          end
        end else if (sck_fall) begin
          // The fall ahead of the first rise of a frame must not consume the buffer.
          if (bit_ctr_q != 3'd0) tx_shift_d = {tx_shift_q[6:0], 1'b0};
          else if (first_rise_q) load = 1'b1;
        end
      end
    endcase

    if (load) begin
      if (txbuf_full_q) begin
        tx_shift_d   = txbuf_q;
        txbuf_full_d = 1'b0;
      end else begin
        tx_shift_d = IDLE_TX_BYTE;
        und_evt    = 1'b1;
      end
    end

    // A same-cycle write lands after the load, so it waits for the next boundary.
    if (bus.tx_data_vld && !txbuf_full_q) begin
      txbuf_d      = bus.tx_data;
      txbuf_full_d = 1'b1;
    end
  end

`ifdef TK1_SPI_SLAVE_ERR_EN
  logic rx_ovr_q, rx_ovr_d, tx_und_q, tx_und_d;

  always_comb begin
    rx_ovr_d = err_clear ? 1'b0 : rx_ovr_q;
    tx_und_d = err_clear ? 1'b0 : tx_und_q;
    if (ovr_evt) rx_ovr_d = 1'b1;
    if (und_evt) tx_und_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ovr_q <= 1'b0;
      tx_und_q <= 1'b0;
    end else begin
      rx_ovr_q <= rx_ovr_d;
      tx_und_q <= tx_und_d;
    end
  end

  assign rx_overrun  = rx_ovr_q;
  assign tx_underrun = tx_und_q;
`else
  logic unused_err;
  assign unused_err  = err_clear ^ ovr_evt ^ und_evt;
  assign rx_overrun  = 1'b0;
  assign tx_underrun = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ss_sync_q    <= '1;
      sck_sync_q   <= '0;
      mosi_sync_q  <= '0;
      ss_hist_q    <= 1'b1;
      sck_hist_q   <= 1'b0;
      bit_ctr_q    <= 3'd0;
      rx_shift_q   <= 8'h00;
      tx_shift_q   <= 8'h00;
      rx_data_q    <= 8'h00;
      txbuf_q      <= 8'h00;
      rx_vld_q     <= 1'b0;
      txbuf_full_q <= 1'b0;
      first_rise_q <= 1'b0;
      frame_end_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ss_sync_q    <= ss_sync_d;
      sck_sync_q   <= sck_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      ss_hist_q    <= ss_hist_d;
      sck_hist_q   <= sck_hist_d;
      bit_ctr_q    <= bit_ctr_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      rx_data_q    <= rx_data_d;
      txbuf_q      <= txbuf_d;
      rx_vld_q     <= rx_vld_d;
      txbuf_full_q <= txbuf_full_d;
      first_rise_q <= first_rise_d;
      frame_end_q  <= frame_end_d;
    end
  end

  assign spi_miso        = (state_q == ST_ACTIVE) & tx_shift_q[7];
  assign spi_miso_en     = (state_q == ST_ACTIVE);
  assign frame_active    = (state_q == ST_ACTIVE);
  assign frame_end       = frame_end_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_data_vld = rx_vld_q;
  assign bus.tx_ready    = ~txbuf_full_q;
endmodule
